axi4_lite_arbiter: RTL and testbench
====================================

AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, address width of requesters and master.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width of requesters and master.
REQ-003 SHALL have port clk_i  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port arst_i  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports req0_i/req1_i  input  1  request level, requester 0 (fetch) / 1 (data).
REQ-006 SHALL have ports we0_i/we1_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0_i/addr1_i  input  AXI_ADDR_WIDTH  request address.
REQ-008 SHALL have ports wdata0_i/wdata1_i  input  AXI_DATA_WIDTH  write data.
REQ-009 SHALL have ports done0_o/done1_o  output  1  one-cycle completion pulse per requester.
REQ-010 SHALL have ports rdata0_o/rdata1_o  output  AXI_DATA_WIDTH  registered read data.
REQ-011 SHALL have ports fault0_o/fault1_o  output  1  registered fault of last completion.
REQ-012 SHALL have ports m_addr_o  output  AXI_ADDR_WIDTH, m_data_o  output  AXI_DATA_WIDTH  to master.
REQ-013 SHALL have ports m_start_read_o/m_start_write_o  output  1  one-cycle start pulses to master.
REQ-014 SHALL have ports m_data_i  input  AXI_DATA_WIDTH, m_read_fault_i/m_write_fault_i/m_done_i  input  1  from master.

Function
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> IDLE; one transaction outstanding at most.
REQ-016 SHALL in IDLE, if any req high, grant one requester and go to ISSUE next cycle; else stay IDLE.
REQ-017 SHALL arbitrate round-robin: 1-bit pointer names the preferred requester; sole requester always wins.
REQ-018 SHALL flip the pointer to the other requester on every completion in WAIT.
REQ-019 SHALL latch grant id, we, addr, wdata at the grant edge; later requester input changes do not affect the transaction.
REQ-020 SHALL hold m_addr_o/m_data_o at latched values from ISSUE through WAIT.
REQ-021 SHALL in ISSUE pulse exactly one of m_start_write_o (we=1) or m_start_read_o (we=0) for one cycle, then go to WAIT.
REQ-022 SHALL ignore m_done_i in IDLE and ISSUE.
REQ-023 SHALL in WAIT stay until m_done_i=1; on that edge go to IDLE and pulse done<id>_o the following cycle.
REQ-024 SHALL on read completion load rdata<id>_o from m_data_i and fault<id>_o from m_read_fault_i.
REQ-025 SHALL on write completion leave rdata<id>_o unchanged and load fault<id>_o from m_write_fault_i.
REQ-026 SHALL keep the non-granted requester's rdata/fault unchanged.
REQ-027 SHALL complete and pulse done for a transaction whose req drops mid-flight.
REQ-028 SHALL treat a req still high in the cycle after its done pulse as a new request (requester drops req on done).
REQ-029 SHALL give latency: req in IDLE at edge N -> start pulse cycle N+1 -> done pulse one cycle after m_done_i.
REQ-030 SHALL never assert both start pulses, or both done pulses, in one cycle.

Reset
REQ-031 SHALL on arst_i=0 immediately force state IDLE, pointer=0 (requester 0 preferred), and all outputs 0.
REQ-032 SHALL abandon an in-flight transaction on reset with no done pulse; master is reset by the same signal.
REQ-033 SHALL start arbitration on the first rising edge after arst_i deasserts.

Verification
REQ-034 SHALL cover single read: req0, we0=0, addr0=0x1000; master returns 0xDEADBEEF after 3 cycles -> one m_start_read_o pulse, m_addr_o=0x1000, done0_o pulse, rdata0_o=0xDEADBEEF, fault0_o=0.
REQ-035 SHALL cover simultaneous requests after reset: req0 read and req1 write 0x55 to 0x2000 -> requester 0 served first, then requester 1 with m_data_o=0x55 and m_start_write_o.
REQ-036 SHALL cover fairness: both req held for 4 transactions -> grant order 0,1,0,1.
REQ-037 SHALL cover faults: read with m_read_fault_i=1 -> fault1_o=1, rdata1_o unchanged; next clean write -> fault1_o=0.
REQ-038 SHALL cover mid-flight changes: addr0 changed and req0 dropped in WAIT -> m_addr_o unchanged, done0_o still pulses.
REQ-039 SHALL cover reset in WAIT: arst_i=0 -> all outputs 0 at once, no done pulse; post-reset req1 alone -> granted.

Source files
------------

// File: rtl/axi4_lite_arbiter_if.sv
// Master-side bus between the two-requester arbiter and the AXI4-Lite master engine.
// The "master" modport is the arbiter's view; "slave" is the engine's view.
interface axi4_lite_arbiter_if #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
);
  logic [AXI_ADDR_WIDTH-1:0] m_addr_o;
  logic [AXI_DATA_WIDTH-1:0] m_data_o;
  logic                      m_start_read_o;
  logic                      m_start_write_o;
  logic [AXI_DATA_WIDTH-1:0] m_data_i;
  logic                      m_read_fault_i;
  logic                      m_write_fault_i;
  logic                      m_done_i;

  modport master (
    output m_addr_o, m_data_o, m_start_read_o, m_start_write_o,
    input  m_data_i, m_read_fault_i, m_write_fault_i, m_done_i
  );

  modport slave (
    input  m_addr_o, m_data_o, m_start_read_o, m_start_write_o,
    output m_data_i, m_read_fault_i, m_write_fault_i, m_done_i
  );
endinterface

// File: rtl/axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master between a fetch (0) and a data (1)
// requester, with a single transaction outstanding at a time.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; grant a requester when any req is high
// ST_ISSUE | pulse the read/write start to the master for one cycle
// ST_WAIT  | wait for m_done_i, then complete back to the granted requester
module axi4_lite_arbiter #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      req0_i,
  input  logic                      req1_i,
  input  logic                      we0_i,
  input  logic                      we1_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr0_i,
  input  logic [AXI_ADDR_WIDTH-1:0] addr1_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata0_i,
  input  logic [AXI_DATA_WIDTH-1:0] wdata1_i,
  output logic                      done0_o,
  output logic                      done1_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata0_o,
  output logic [AXI_DATA_WIDTH-1:0] rdata1_o,
  output logic                      fault0_o,
  output logic                      fault1_o,
  axi4_lite_arbiter_if.master       m
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                    state;
  state_t                    state_nxt;
  logic                      ptr;
  logic                      gnt_id;
  logic                      lat_we;
  logic [AXI_ADDR_WIDTH-1:0] lat_addr;
  logic [AXI_DATA_WIDTH-1:0] lat_wdata;
  logic                      any_req;
  logic                      gnt_sel;
  logic                      grant;
  logic                      complete;
  logic                      cpl_fault;

  assign any_req = req0_i | req1_i;
  // The pointer only breaks ties; a lone requester wins regardless of it.
  assign gnt_sel = (req0_i && req1_i) ? ptr : req1_i;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant     = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (m.m_done_i) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign cpl_fault = lat_we ? m.m_write_fault_i : m.m_read_fault_i;

  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      ptr       <= 1'b0;
      gnt_id    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      done0_o   <= 1'b0;
      done1_o   <= 1'b0;
      rdata0_o  <= '0;
      rdata1_o  <= '0;
      fault0_o  <= 1'b0;
      fault1_o  <= 1'b0;
    end else begin
      done0_o <= 1'b0;
      done1_o <= 1'b0;
      if (grant) begin
        gnt_id    <= gnt_sel;
        lat_we    <= gnt_sel ? we1_i    : we0_i;
        lat_addr  <= gnt_sel ? addr1_i  : addr0_i;
        lat_wdata <= gnt_sel ? wdata1_i : wdata0_i;
      end
      if (complete) begin
        ptr <= ~gnt_id;
        if (gnt_id) begin
          done1_o  <= 1'b1;
          fault1_o <= cpl_fault;
          if (!lat_we) rdata1_o <= m.m_data_i;
        end else begin
          done0_o  <= 1'b1;
          fault0_o <= cpl_fault;
          if (!lat_we) rdata0_o <= m.m_data_i;
        end
      end
    end
  end

  assign m.m_addr_o        = lat_addr;
  assign m.m_data_o        = lat_wdata;
  assign m.m_start_read_o  = (state == ST_ISSUE) && !lat_we;
  assign m.m_start_write_o = (state == ST_ISSUE) &&  lat_we;

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: a vector table of single-requester transactions
// plus hand-written sequences for contention, fairness, mid-flight changes and reset.
module tb_axi4_lite_arbiter;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [63:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        done0, done1, fault0, fault1;
  logic [31:0] rdata0, rdata1;

  axi4_lite_arbiter_if #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32)) bus ();

  axi4_lite_arbiter #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(32)) dut (
    .clk_i(clk), .arst_i(arst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .done0_o(done0), .done1_o(done1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .fault0_o(fault0), .fault1_o(fault1), .m(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Master model: answers each start after resp_lat cycles unless reset intervenes.
  int          resp_lat = 2;
  logic [31:0] resp_data = '0;
  logic        resp_rf = 1'b0, resp_wf = 1'b0;

  initial begin
    bit aborted;
    bus.m_done_i = 1'b0;
    bus.m_data_i = '0;
    bus.m_read_fault_i = 1'b0;
    bus.m_write_fault_i = 1'b0;
    forever begin
      @(negedge clk);
      if (arst && (bus.m_start_read_o || bus.m_start_write_o)) begin
        aborted = 1'b0;
        for (int i = 0; i < resp_lat; i++) begin
          @(negedge clk);
          if (!arst) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) begin
          bus.m_done_i = 1'b1;
          bus.m_data_i = resp_data;
          bus.m_read_fault_i = resp_rf;
          bus.m_write_fault_i = resp_wf;
          @(negedge clk);
          bus.m_done_i = 1'b0;
          bus.m_read_fault_i = 1'b0;
          bus.m_write_fault_i = 1'b0;
        end
      end
    end
  end

  // Bus monitor
  int          n_start = 0, n_done = 0, n_both_start = 0, n_both_done = 0;
  int          st_cyc = 0, dn_cyc = 0;
  logic        st_we = 1'b0, dn_id = 1'b0;
  logic [63:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [63:0] start_q[$];
  logic        start_we_q[$];
  logic [31:0] start_data_q[$];

  always @(negedge clk) begin
    if (bus.m_start_read_o || bus.m_start_write_o) begin
      n_start++;
      st_cyc  = cyc;
      st_we   = bus.m_start_write_o;
      st_addr = bus.m_addr_o;
      st_data = bus.m_data_o;
      start_q.push_back(bus.m_addr_o);
      start_we_q.push_back(bus.m_start_write_o);
      start_data_q.push_back(bus.m_data_o);
    end
    if (bus.m_start_read_o && bus.m_start_write_o) n_both_start++;
    if (done0 || done1) begin
      n_done++;
      dn_cyc = cyc;
      dn_id  = done1;
    end
    if (done0 && done1) n_both_done++;
  end

  typedef struct {
    bit          id;
    bit          we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [31:0] mdata;
    bit          rf;
    bit          wf;
    int          lat;
    logic [31:0] exp_rdata;
    bit          exp_fault;
  } vec_t;

  logic [31:0] sh_r[2];
  bit          sh_f[2];

  task automatic run_one(input vec_t v);
    int  s0, req_cyc;
    bit  got;
    bit  oth;
    s0 = n_start;
    resp_lat = v.lat; resp_data = v.mdata; resp_rf = v.rf; resp_wf = v.wf;
    if (v.id) begin we1 = v.we; addr1 = v.addr; wdata1 = v.wdata; req1 = 1'b1; end
    else      begin we0 = v.we; addr0 = v.addr; wdata0 = v.wdata; req0 = 1'b1; end
    req_cyc = cyc;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done0 || done1) begin
        got = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    oth = ~v.id;
    check("start_count", 64'(n_start - s0), 64'd1);
    check("start_kind_we", 64'(st_we), 64'(v.we));
    check("m_addr", st_addr, v.addr);
    if (v.we) check("m_data", 64'(st_data), 64'(v.wdata));
    check("req_to_start", 64'(st_cyc - req_cyc), 64'd1);
    check("done_id", 64'(dn_id), 64'(v.id));
    check("start_to_done", 64'(dn_cyc - st_cyc), 64'(v.lat + 1));
    check("rdata_granted", 64'(v.id ? rdata1 : rdata0), 64'(v.exp_rdata));
    check("fault_granted", 64'(v.id ? fault1 : fault0), 64'(v.exp_fault));
    check("rdata_other", 64'(oth ? rdata1 : rdata0), 64'(sh_r[oth]));
    check("fault_other", 64'(oth ? fault1 : fault0), 64'(sh_f[oth]));
    sh_r[v.id] = v.exp_rdata;
    sh_f[v.id] = v.exp_fault;
  endtask

  task automatic do_reset();
    arst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk); @(negedge clk);
    arst = 1'b1;
    sh_r[0] = '0; sh_r[1] = '0; sh_f[0] = 1'b0; sh_f[1] = 1'b0;
    @(negedge clk);
  endtask

  // Both requesters hold req until they have seen c0 / c1 completions.
  task automatic run_pair(input int c0, input int c1);
    resp_lat = 2; resp_data = 32'h0; resp_rf = 1'b0; resp_wf = 1'b0;
    we0 = 1'b0; addr0 = 64'h1000; wdata0 = 32'h0;
    we1 = 1'b1; addr1 = 64'h2000; wdata1 = 32'h55;
    req0 = (c0 > 0); req1 = (c1 > 0);
    for (int i = 0; i < 400 && (req0 || req1); i++) begin
      @(negedge clk);
      if (done0) begin c0--; if (c0 == 0) req0 = 1'b0; end
      if (done1) begin c1--; if (c1 == 0) req1 = 1'b0; end
    end
    check("pair_finished", 64'({req0, req1}), 64'd0);
    @(negedge clk);
  endtask

  task automatic wait_start(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bus.m_start_read_o || bus.m_start_write_o) got = 1'b1;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int  d0, s0, ndone;
    bit  got;
    vecs[0] = '{1'b0, 1'b0, 64'h1000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 3, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 64'h2000, 32'h55,       32'hFFFFFFFF, 1'b0, 1'b0, 2, 32'h0,        1'b0};
    vecs[2] = '{1'b1, 1'b0, 64'h2004, 32'h0,        32'h12345678, 1'b0, 1'b0, 4, 32'h12345678, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 64'h2008, 32'h0,        32'h12345678, 1'b1, 1'b0, 2, 32'h12345678, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 64'h200C, 32'hA5A5A5A5, 32'h0,        1'b1, 1'b0, 1, 32'h12345678, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 64'h1004, 32'hCAFEF00D, 32'h0,        1'b0, 1'b1, 2, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 64'h1008, 32'h0,        32'h0BADF00D, 1'b0, 1'b1, 1, 32'h0BADF00D, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 64'h100C, 32'h0,        32'h0,        1'b1, 1'b0, 5, 32'h0,        1'b1};

    @(negedge clk);
    check("reset_outputs",
          {done0, done1, fault0, fault1, bus.m_start_read_o, bus.m_start_write_o,
           rdata0 | rdata1, 26'h0}, 64'h0);
    check("reset_m_addr", bus.m_addr_o, 64'h0);
    do_reset();

    for (int k = 0; k < 8; k++) run_one(vecs[k]);

    // Contention straight after reset: requester 0 wins, then requester 1 writes.
    do_reset();
    start_q.delete(); start_we_q.delete(); start_data_q.delete();
    run_pair(1, 1);
    check("pair_starts", 64'(start_q.size()), 64'd2);
    if (start_q.size() == 2) begin
      check("pair_first_addr", start_q[0], 64'h1000);
      check("pair_first_read", 64'(start_we_q[0]), 64'd0);
      check("pair_second_addr", start_q[1], 64'h2000);
      check("pair_second_write", 64'(start_we_q[1]), 64'd1);
      check("pair_second_data", 64'(start_data_q[1]), 64'h55);
    end

    // Fairness: both held for four transactions.
    do_reset();
    start_q.delete();
    run_pair(2, 2);
    check("fair_starts", 64'(start_q.size()), 64'd4);
    if (start_q.size() == 4) begin
      check("fair_order", {start_q[0][15:0], start_q[1][15:0], start_q[2][15:0], start_q[3][15:0]},
            64'h1000_2000_1000_2000);
    end

    // Mid-flight: address changes and req drops while waiting.
    resp_lat = 6; resp_data = 32'h600DD00D; resp_rf = 1'b0; resp_wf = 1'b0;
    we0 = 1'b0; addr0 = 64'h3000; req0 = 1'b1;
    s0 = n_start;
    wait_start(got);
    check("mid_start_seen", 64'(got), 64'd1);
    check("mid_m_addr_issue", bus.m_addr_o, 64'h3000);
    @(negedge clk); @(negedge clk);
    addr0 = 64'h3FF0; req0 = 1'b0; we0 = 1'b1;
    @(negedge clk);
    check("mid_m_addr_wait", bus.m_addr_o, 64'h3000);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (done0) got = 1'b1;
    end
    check("mid_done0", 64'(got), 64'd1);
    check("mid_m_addr_done", bus.m_addr_o, 64'h3000);
    check("mid_rdata0", 64'(rdata0), 64'h600DD00D);
    repeat (4) @(negedge clk);
    check("mid_no_restart", 64'(n_start - s0), 64'd1);

    // Reset while waiting: outputs clear at once, no completion follows.
    resp_lat = 20; resp_data = 32'h77777777;
    we0 = 1'b0; addr0 = 64'h4000; req0 = 1'b1;
    wait_start(got);
    check("rst_start_seen", 64'(got), 64'd1);
    @(negedge clk); @(negedge clk);
    d0 = n_done;
    arst = 1'b0;
    #1;
    check("rst_done_fault", 64'({done0, done1, fault0, fault1}), 64'd0);
    check("rst_rdata", 64'({rdata0, rdata1}), 64'd0);
    check("rst_m_addr", bus.m_addr_o, 64'h0);
    check("rst_m_data_starts", 64'({bus.m_data_o, bus.m_start_read_o, bus.m_start_write_o}), 64'd0);
    @(negedge clk); @(negedge clk);
    req0 = 1'b0;
    arst = 1'b1;
    sh_r[0] = '0; sh_r[1] = '0; sh_f[0] = 1'b0; sh_f[1] = 1'b0;
    repeat (25) @(negedge clk);
    ndone = n_done - d0;
    check("rst_no_done", 64'(ndone), 64'd0);
    run_one('{1'b1, 1'b1, 64'h2020, 32'h77, 32'h0, 1'b0, 1'b0, 2, 32'h0, 1'b0});

    check("never_both_starts", 64'(n_both_start), 64'd0);
    check("never_both_dones", 64'(n_both_done), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
